gppcu_instr_sequencer: RTL and testbench
========================================

Name: gppcu_instr_sequencer

Overview:
- Instruction sequencer between the instruction memory and the GPPCU core's instruction port.
- On a host start command it fetches instructions sequentially from a start address and streams them to the core over a valid/ready handshake.
- Stops on a HALT opcode, on address-space end, or on host abort. Reports busy and done status and an issued-instruction count.

Parameters:
- DBW, 32, instruction width.
- IABW, 10, instruction memory address width.
- OPC_LSB, 27, bit position of the 5-bit opcode field in an instruction.
- HALT_OPC, 5'h1F, opcode value that terminates a program.
- CNTW, 16, width of the issued-instruction counter.

Ports:
- iACLK  in  1  clock; all state changes on the rising edge.
- inRST  in  1  asynchronous, active-low reset.
- iSTART  in  1  start pulse; sampled only in IDLE.
- iSTART_ADDR  in  IABW  first instruction address; sampled with iSTART.
- iABORT  in  1  abort the current program.
- oBUSY  out  1  high while state is RUN.
- oDONE  out  1  one-cycle pulse on normal termination.
- oINSTR_CNT  out  CNTW  instructions accepted by the core in this run.
- oIMEM_ADDR  out  IABW  instruction memory read address (current PC).
- oIMEM_RD  out  1  read strobe.
- iIMEM_RDATA  in  DBW  read data, valid exactly one cycle after the strobe.
- oINSTR  out  DBW  instruction to the core (FIFO head).
- oINSTR_VALID  out  1  instruction valid to the core.
- iINSTR_READY  in  1  core ready.

Behaviour:
- Reset values: state IDLE, PC 0, FIFO empty, in-flight flag 0, end flag 0, oBUSY 0, oDONE 0, oINSTR_CNT 0, oIMEM_RD 0, oINSTR_VALID 0.
- States are IDLE and RUN. oDONE is a registered pulse.
- IDLE to RUN: iSTART=1 and iABORT=0. On this transition, load PC with iSTART_ADDR and clear the counter, the FIFO and the end flag. iSTART in RUN is ignored.
- Buffer: 2-entry FIFO. oINSTR is the head; oINSTR_VALID = (FIFO not empty) and (head opcode != HALT_OPC).
- Pop condition: oINSTR_VALID and iINSTR_READY.
- Fetch rule: in RUN, oIMEM_RD = ~end and (count + inflight - pop) < 2.
  - This path is combinational from iINSTR_READY.
  - With iINSTR_READY held high, it gives one instruction per cycle.
- On each read, PC increments. A read at PC = 2^IABW-1 sets end instead of wrapping.
- Read data is written to the FIFO the cycle after the strobe, only if the state is still RUN. Otherwise it is discarded.
- Latency: iSTART sampled at edge 0; first oIMEM_RD in cycle 1; first oINSTR_VALID in cycle 3.
- HALT at the FIFO head:
  - The HALT word is never presented to the core.
  - The FIFO is flushed, the state goes to IDLE, and oDONE pulses for one cycle.
  - Any read still in flight is dropped.
- End of address space: with end=1, FIFO empty and no read in flight, the state goes to IDLE with an oDONE pulse.
- iABORT in RUN: next state IDLE, FIFO flushed, no oDONE pulse. oINSTR_CNT holds its value.
- iABORT and iSTART in the same cycle: abort wins and start is ignored.
- oINSTR_CNT increments on each pop. It saturates at all-ones and holds after termination until the next start.
- Reset asserted mid-run: all state clears immediately (asynchronous). oINSTR_VALID and oIMEM_RD drop without waiting for a clock edge.
- The FIFO never overflows. The fetch rule guarantees count + inflight <= 2.

Test Plan:
- Start at 0x010 with memory holding ADD, SUB, MUL, HALT and iINSTR_READY=1:
  - first valid at cycle 3;
  - three instructions issued on consecutive cycles;
  - oDONE pulses once; oINSTR_CNT=3; oBUSY low after the pulse.
- Backpressure: same program with iINSTR_READY toggling 1,0,0,1,…:
  - no instruction is lost or duplicated; oIMEM_RD never pushes count+inflight above 2;
  - instruction order is preserved; final oINSTR_CNT=3.
- Start at 0x3FE with no HALT in memory:
  - exactly two reads (0x3FE, 0x3FF), no wrap to 0;
  - two instructions issued; oDONE pulses; oINSTR_CNT=2.
- Abort after 5 issued instructions:
  - next cycle oBUSY=0, oINSTR_VALID=0, no oDONE pulse; oINSTR_CNT stays 5;
  - the stale read returning after abort is not issued.
- Start and abort together in IDLE: remains IDLE. iSTART while busy: PC unaffected.
- Assert inRST mid-run between clock edges: oINSTR_VALID and oIMEM_RD drop immediately; all outputs are at reset values.

Source files
------------

// File: rtl/gppcu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gppcu_instr_sequencer
// Brief    : Fetches a program from instruction memory starting at a host
//            supplied address and streams it to the GPPCU core over a
//            valid/ready handshake. Terminates on HALT, on the end of the
//            address space, or on host abort.
// Revision : 1.0 - initial release
// ============================================================================
module gppcu_instr_sequencer #(
    parameter int         DBW      = 32,
    parameter int         IABW     = 10,
    parameter int         OPC_LSB  = 27,
    parameter logic [4:0] HALT_OPC = 5'h1F,
    parameter int         CNTW     = 16
) (
    input  logic            iACLK,
    input  logic            inRST,
    input  logic            iSTART,
    input  logic [IABW-1:0] iSTART_ADDR,
    input  logic            iABORT,
    output logic            oBUSY,
    output logic            oDONE,
    output logic [CNTW-1:0] oINSTR_CNT,
    output logic [IABW-1:0] oIMEM_ADDR,
    output logic            oIMEM_RD,
    input  logic [DBW-1:0]  iIMEM_RDATA,
    output logic [DBW-1:0]  oINSTR,
    output logic            oINSTR_VALID,
    input  logic            iINSTR_READY
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IABW-1:0] c_PC_LAST = {IABW{1'b1}};
    localparam logic [IABW-1:0] c_PC_ONE  = {{(IABW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] c_CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Control state
    logic [0:0]      state_q, state_d;
    logic [IABW-1:0] pc_q, pc_d;
    logic            end_q, end_d;
    logic            inflight_q, inflight_d;
    logic            done_q;
    logic [CNTW-1:0] icnt_q;

    // Two-entry instruction FIFO
    logic [DBW-1:0]  fifo0_q, fifo1_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fcnt_q;

    // Combinational helpers
    logic            w_run;
    logic [DBW-1:0]  w_head;
    logic            w_head_halt;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic [2:0]      w_occ;
    logic            w_rd;
    logic            w_start;
    logic            w_normal_end;
    logic            w_flush;

    assign w_run  = (state_q == ST_RUN);
    assign w_head = rd_ptr_q ? fifo1_q : fifo0_q;

    // HALT at the head is consumed internally and never shown to the core
    assign w_head_halt = (fcnt_q != 2'd0) && (w_head[OPC_LSB +: 5] == HALT_OPC);
    assign w_valid     = w_run && (fcnt_q != 2'd0) && !w_head_halt;
    assign w_pop       = w_valid && iINSTR_READY;

    // Occupancy after this cycle's pop; a new read may only be issued when
    // it still fits, so FIFO entries plus the read in flight never exceed 2.
    assign w_occ = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_rd  = w_run && !end_q && (w_occ < 3'd2);

    // Returning data lands only if the run is not ending this very cycle
    assign w_push = w_run && inflight_q && !iABORT && !w_head_halt;

    assign w_start      = !w_run && iSTART && !iABORT;
    assign w_normal_end = w_run && !iABORT &&
                          (w_head_halt || (end_q && (fcnt_q == 2'd0) && !inflight_q));
    assign w_flush      = w_start || (w_run && (iABORT || w_normal_end));

    // Next-state for run control, program counter and end-of-space flag
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        end_d      = end_q;
        inflight_d = 1'b0;
        if (w_start) begin
            state_d = ST_RUN;
            pc_d    = iSTART_ADDR;
            end_d   = 1'b0;
        end else if (w_run) begin
            if (iABORT || w_normal_end) begin
                state_d = ST_IDLE;
            end
            if (w_rd) begin
                inflight_d = 1'b1;
                if (pc_q == c_PC_LAST) begin
                    end_d = 1'b1;
                end else begin
                    pc_d = pc_q + c_PC_ONE;
                end
            end
        end
    end

    // Control registers
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            end_q      <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            end_q      <= end_d;
            inflight_q <= inflight_d;
            done_q     <= w_normal_end;
        end
    end

    // FIFO storage and pointers; flushed on start and on any termination
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            fifo0_q  <= '0;
            fifo1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fcnt_q   <= 2'd0;
        end else if (w_flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fcnt_q   <= 2'd0;
        end else begin
            if (w_push) begin
                if (wr_ptr_q) begin
                    fifo1_q <= iIMEM_RDATA;
                end else begin
                    fifo0_q <= iIMEM_RDATA;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fcnt_q <= fcnt_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Issued-instruction counter: cleared on start, saturating, holds after the run
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            icnt_q <= '0;
        end else if (w_start) begin
            icnt_q <= '0;
        end else if (w_pop && (icnt_q != c_CNT_MAX)) begin
            icnt_q <= icnt_q + c_CNT_ONE;
        end
    end

    assign oBUSY        = w_run;
    assign oDONE        = done_q;
    assign oINSTR_CNT   = icnt_q;
    assign oIMEM_ADDR   = pc_q;
    assign oIMEM_RD     = w_rd;
    assign oINSTR       = w_head;
    assign oINSTR_VALID = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_gppcu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gppcu_instr_sequencer
// Brief    : Randomised and directed bench for gppcu_instr_sequencer with an
//            instruction-memory responder and a program-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gppcu_instr_sequencer;

    localparam int         DBW  = 32;
    localparam int         IABW = 10;
    localparam int         CNTW = 16;
    localparam logic [4:0] HALT = 5'h1F;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [IABW-1:0] saddr;
    logic            abort;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] icnt;
    logic [IABW-1:0] iaddr;
    logic            ird;
    logic [DBW-1:0]  rdata;
    logic [DBW-1:0]  instr;
    logic            ivalid;
    logic            rdy;

    always #5 clk = ~clk;

    gppcu_instr_sequencer dut (
        .iACLK        (clk),
        .inRST        (rst_n),
        .iSTART       (start),
        .iSTART_ADDR  (saddr),
        .iABORT       (abort),
        .oBUSY        (busy),
        .oDONE        (done),
        .oINSTR_CNT   (icnt),
        .oIMEM_ADDR   (iaddr),
        .oIMEM_RD     (ird),
        .iIMEM_RDATA  (rdata),
        .oINSTR       (instr),
        .oINSTR_VALID (ivalid),
        .iINSTR_READY (rdy)
    );

    logic [DBW-1:0] mem [1024];

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor (samples at negedge) ----------------
    int              run_id  = 0;
    int              seen_id = 0;
    int              cyc, first_v, first_r, first_p, last_p, done_cnt, max_out;
    logic [31:0]     got[$];
    logic [IABW-1:0] reads[$];
    logic            pend  = 1'b0;
    logic [IABW-1:0] paddr = '0;

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id  = run_id;
            got.delete();
            reads.delete();
            cyc      = 0;
            first_v  = -1;
            first_r  = -1;
            first_p  = -1;
            last_p   = -1;
            done_cnt = 0;
            max_out  = 0;
        end
        cyc++;
        pend  = rst_n && ird;
        paddr = iaddr;
        if (rst_n) begin
            if (ivalid && first_v < 0) first_v = cyc;
            if (ird && first_r < 0) first_r = cyc;
            if (ivalid && rdy) begin
                got.push_back(instr);
                if (first_p < 0) first_p = cyc;
                last_p = cyc;
            end
            if (ird) reads.push_back(iaddr);
            if (int'(reads.size()) - int'(got.size()) > max_out)
                max_out = int'(reads.size()) - int'(got.size());
            if (done) done_cnt++;
        end
    end

    // Memory responder: data valid the cycle after the strobe, garbage otherwise
    always begin
        @(posedge clk);
        #1;
        rdata = pend ? mem[paddr] : DBW'($urandom);
    end

    // ---------------- stimulus helpers ----------------
    int mode = 0;
    int pat  = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((pat % 3) == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        pat++;
    endtask

    function automatic logic [31:0] rword();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == HALT) w[31:27] = 5'h00;
        return w;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = rword();
    endtask

    // Run one program and compare against the reference: the issued stream is
    // every word from the start address up to (not including) the first HALT,
    // or up to the last address of memory.
    task automatic run_prog(input logic [IABW-1:0] s, input int md, input int poke_at,
                            input int exp_reads, input bit chk_lat, input string nm);
        logic [31:0] exp[$];
        int          n;
        bit          seq_ok;
        for (int a = int'(s); a < 1024; a++) begin
            if (mem[a][31:27] == HALT) break;
            exp.push_back(mem[a]);
        end
        mode = md;
        pat  = 0;
        step();
        start = 1'b1;
        saddr = s;
        step();
        start = 1'b0;
        run_id++;
        n = 0;
        while (busy && n < 3000) begin
            if (n == poke_at) begin
                start = 1'b1;
                saddr = 10'h200;
            end
            step();
            start = 1'b0;
            n++;
        end
        chk({nm, " finish"}, 32'(n < 3000), 32'd1);
        step();
        step();
        chk({nm, " n_issued"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({nm, " instr"}, got[i], exp[i]);
        chk({nm, " cnt"}, 32'(icnt), exp.size());
        chk({nm, " done_pulses"}, done_cnt, 1);
        chk({nm, " busy_after"}, 32'(busy), 32'd0);
        chk({nm, " valid_after"}, 32'(ivalid), 32'd0);
        chk({nm, " occupancy"}, 32'(max_out <= 2), 32'd1);
        seq_ok = 1'b1;
        for (int i = 0; i < reads.size(); i++)
            if (int'(reads[i]) != int'(s) + i) seq_ok = 1'b0;
        chk({nm, " read_seq"}, 32'(seq_ok), 32'd1);
        if (exp_reads >= 0) chk({nm, " n_reads"}, reads.size(), exp_reads);
        if (chk_lat) begin
            chk({nm, " first_rd_cyc"}, first_r, 1);
            chk({nm, " first_valid_cyc"}, first_v, 3);
            chk({nm, " back_to_back"}, last_p - first_p, exp.size() - 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        saddr = '0;
        rdy   = 1'b0;
        rdata = '0;
        fill_mem();
        step();
        step();
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst cnt", 32'(icnt), 0);
        chk("rst rd", 32'(ird), 0);
        chk("rst valid", 32'(ivalid), 0);
        chk("rst addr", 32'(iaddr), 0);
        rst_n = 1'b1;
        step();

        // ADD, SUB, MUL, HALT at 0x010 with ready held high
        fill_mem();
        mem[16] = {5'h01, 27'h0000123};
        mem[17] = {5'h02, 27'h0000456};
        mem[18] = {5'h03, 27'h0000789};
        mem[19] = {HALT,  27'h0000000};
        run_prog(10'h010, 0, -1, -1, 1'b1, "basic");

        // Same program under backpressure pattern 1,0,0
        run_prog(10'h010, 1, -1, -1, 1'b0, "bp");

        // Top of address space, no HALT: exactly two reads, no wrap
        fill_mem();
        run_prog(10'h3FE, 0, -1, 2, 1'b0, "edge");

        // Start pulse while running must not disturb the PC
        fill_mem();
        mem[10'h040 + 20][31:27] = HALT;
        run_prog(10'h040, 1, 6, -1, 1'b0, "poke");

        // Randomised programs
        for (int r = 0; r < 8; r++) begin
            int s, len;
            fill_mem();
            s   = $urandom_range(0, 1023);
            len = $urandom_range(0, 12);
            if (s + len < 1024 && $urandom_range(0, 3) != 0) mem[s + len][31:27] = HALT;
            run_prog(10'(s), 2, -1, -1, 1'b0, "rand");
        end

        // Abort after five issued instructions
        fill_mem();
        mode = 0;
        step();
        start = 1'b1;
        saddr = 10'h100;
        step();
        start = 1'b0;
        run_id++;
        n = 0;
        while (got.size() < 5 && n < 100) begin
            step();
            n++;
        end
        chk("abort reach5", 32'(n < 100), 1);
        rdy   = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort valid", 32'(ivalid), 0);
        chk("abort cnt", 32'(icnt), 5);
        for (int i = 0; i < 4; i++) step();
        chk("abort issued", got.size(), 5);
        chk("abort no_done", done_cnt, 0);
        chk("abort cnt_hold", 32'(icnt), 5);
        chk("abort valid_late", 32'(ivalid), 0);

        // Start and abort together in IDLE
        step();
        start = 1'b1;
        abort = 1'b1;
        saddr = 10'h005;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa busy", 32'(busy), 0);
        step();
        chk("sa busy2", 32'(busy), 0);
        chk("sa rd", 32'(ird), 0);

        // Asynchronous reset in the middle of a cycle during a run
        fill_mem();
        mode = 0;
        step();
        start = 1'b1;
        saddr = 10'h080;
        step();
        start = 1'b0;
        run_id++;
        n = 0;
        while (!(ivalid && ird) && n < 50) begin
            step();
            n++;
        end
        chk("ares active", 32'(ivalid && ird), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ares valid", 32'(ivalid), 0);
        chk("ares rd", 32'(ird), 0);
        chk("ares busy", 32'(busy), 0);
        chk("ares done", 32'(done), 0);
        chk("ares cnt", 32'(icnt), 0);
        chk("ares addr", 32'(iaddr), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ares idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
`default_nettype wire
